// File: rtl/cache_control_pkg.sv
// Shared types and encodings for the L1 cache controller and its datapath.
//   lc3b_cache_state_t : controller FSM states
//   ADDR_*             : addressmux_sel encodings (CPU address / way writeback address)
//   DIN_*              : datainmux_sel encodings (fill data / merged CPU write block)
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } lc3b_cache_state_t;

    localparam logic [1:0] ADDR_CPU = 2'd0;
    localparam logic [1:0] ADDR_WB0 = 2'd1;
    localparam logic [1:0] ADDR_WB1 = 2'd2;

    localparam logic DIN_PMEM = 1'b0;
    localparam logic DIN_CPU  = 1'b1;

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter used for cache hit/miss statistics.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears count
//   inc   : increment request; ignored once count is all-ones
//   count : current value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_control.sv
// Controller FSM for a 2-way, write-back, write-allocate L1 cache.
// Sequences hits, victim writeback and line fill, drives all array write
// enables and mux selects of the datapath, and keeps hit/miss statistics.
//   clk, rst_n                  : clock, async active-low reset
//   mem_read/mem_write/mem_resp : CPU request port (resp is a 1-cycle pulse)
//   pmem_read/pmem_write/pmem_resp : physical memory port
//   ishit*_out, dirtyarr*_out, lru_out : live status from the datapath
//   datainmux_sel, addressmux_sel, *_write, dirty_in : datapath controls
//   hit_count, miss_count       : saturating statistics counters
module cache_control
    import lc3b_types::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             ishit0_out,
    input  logic             ishit1_out,
    input  logic             dirtyarr0_out,
    input  logic             dirtyarr1_out,
    input  logic             lru_out,
    output logic             datainmux_sel,
    output logic [1:0]       addressmux_sel,
    output logic             dataarr0_write,
    output logic             dataarr1_write,
    output logic             valid0_write,
    output logic             valid1_write,
    output logic             tag0_write,
    output logic             tag1_write,
    output logic             dirtyarr0_write,
    output logic             dirtyarr1_write,
    output logic             dirty_in,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    lc3b_cache_state_t state, next_state;

    logic req, hit, hit_way, victim_dirty;
    logic miss_seen, miss_seen_set, miss_seen_clr;
    logic hit_inc, miss_inc;

    assign req          = mem_read | mem_write;
    assign hit          = ishit0_out | ishit1_out;
    // way0 wins if both hit lines are (illegally) asserted
    assign hit_way      = ~ishit0_out;
    assign victim_dirty = lru_out ? dirtyarr1_out : dirtyarr0_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            miss_seen <= 1'b0;
        end else begin
            state <= next_state;
            if (miss_seen_set) begin
                miss_seen <= 1'b1;
            end else if (miss_seen_clr) begin
                miss_seen <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state      = state;
        mem_resp        = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        datainmux_sel   = DIN_PMEM;
        addressmux_sel  = ADDR_CPU;
        dataarr0_write  = 1'b0;
        dataarr1_write  = 1'b0;
        valid0_write    = 1'b0;
        valid1_write    = 1'b0;
        tag0_write      = 1'b0;
        tag1_write      = 1'b0;
        dirtyarr0_write = 1'b0;
        dirtyarr1_write = 1'b0;
        dirty_in        = 1'b0;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;
        miss_seen_set   = 1'b0;
        miss_seen_clr   = 1'b0;

        case (state)
            IDLE: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    // a write (including read+write) merges CPU data and marks the line dirty
                    if (mem_write) begin
                        datainmux_sel = DIN_CPU;
                        dirty_in      = 1'b1;
                        if (hit_way) begin
                            dataarr1_write  = 1'b1;
                            dirtyarr1_write = 1'b1;
                        end else begin
                            dataarr0_write  = 1'b1;
                            dirtyarr0_write = 1'b1;
                        end
                    end
                    // the retry hit that follows a miss is not counted as a hit
                    hit_inc       = ~miss_seen;
                    miss_seen_clr = 1'b1;
                end else if (req) begin
                    miss_inc      = 1'b1;
                    miss_seen_set = 1'b1;
                    next_state    = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write     = 1'b1;
                addressmux_sel = lru_out ? ADDR_WB1 : ADDR_WB0;
                if (pmem_resp) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read      = 1'b1;
                addressmux_sel = ADDR_CPU;
                if (pmem_resp) begin
                    datainmux_sel = DIN_PMEM;
                    dirty_in      = 1'b0;
                    if (lru_out) begin
                        dataarr1_write  = 1'b1;
                        tag1_write      = 1'b1;
                        valid1_write    = 1'b1;
                        dirtyarr1_write = 1'b1;
                    end else begin
                        dataarr0_write  = 1'b1;
                        tag0_write      = 1'b1;
                        valid0_write    = 1'b1;
                        dirtyarr0_write = 1'b1;
                    end
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    sat_counter #(.WIDTH(CNT_W)) u_hit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_miss_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (miss_count)
    );

endmodule
